// File: rtl/debug_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : debug_trace_buffer
//  Brief    : Circular trace buffer for the cpu32e2 debug bundle with a
//             PC-match breakpoint, stop-on-full/overwrite modes and a
//             first-word-fall-through valid/ready drain port.
//  Revision : 1.0  initial release
// ============================================================================

package debugPkg;
    // Core debug bundle (1124 bits). Only the named fields are consumed by
    // the trace buffer; the remainder is carried as an opaque field.
    typedef struct packed {
        logic [1080:0] reserved;
        logic          machineCycleDone;
        logic [31:0]   nextPCState;
        logic [3:0]    flagsState;
        logic [4:0]    causeState;
        logic          interruptEnableState;
    } debugLines;
endpackage

module debug_trace_buffer #(
    parameter  int DEPTH   = 16,
    parameter  int STAMP_W = 16,
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int EW      = STAMP_W + 42
) (
    input  logic                clk,
    input  logic                reset,
    input  debugPkg::debugLines debugIn,
    input  logic                enable,
    input  logic                stopOnFull,
    input  logic                breakEnable,
    input  logic [31:0]         breakAddress,
    input  logic                clearTrace,
    output logic                haltRequest,
    output logic                frozen,
    output logic                overflow,
    output logic [CW-1:0]       count,
    output logic                readValid,
    input  logic                readReady,
    output logic [EW-1:0]       readData
);

    localparam logic [0:0]    ARMED    = 1'b0;
    localparam logic [0:0]    FROZEN   = 1'b1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]         state_q, state_d;
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [STAMP_W-1:0] stamp_q;
    logic               halt_q, halt_d;
    logic               ovf_q, ovf_d;
    logic [EW-1:0]      mem_q [DEPTH];

    logic               capture;
    logic               brkHit;
    logic               pop;
    logic               full;
    logic               doWrite;
    logic [EW-1:0]      entry;
    logic               unused_reserved;

    // Bits of the bundle the trace buffer never looks at.
    assign unused_reserved = ^debugIn.reserved;

    assign full    = (count_q == FULL_CNT);
    assign pop     = (count_q != '0) && readReady;
    assign capture = (state_q == ARMED) && enable && debugIn.machineCycleDone && !clearTrace;
    assign brkHit  = capture && breakEnable && (debugIn.nextPCState == breakAddress);
    assign entry   = {stamp_q, debugIn.causeState, debugIn.interruptEnableState,
                      debugIn.flagsState, debugIn.nextPCState};

    // Next-state logic for pointers, occupancy, sticky flags and mode.
    always_comb begin
        state_d = state_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        halt_d  = halt_q;
        ovf_d   = ovf_q;
        doWrite = 1'b0;
        if (clearTrace) begin
            state_d = ARMED;
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
            halt_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (capture) begin
                if (!full || pop) begin
                    // Room available, or the pop frees the slot this cycle.
                    doWrite = 1'b1;
                    wrPtr_d = wrPtr_q + PTR_ONE;
                end else if (stopOnFull) begin
                    // Entry dropped; stop capturing until cleared.
                    state_d = FROZEN;
                end else begin
                    // Overwrite the oldest entry: head moves with the tail.
                    doWrite = 1'b1;
                    wrPtr_d = wrPtr_q + PTR_ONE;
                    rdPtr_d = rdPtr_q + PTR_ONE;
                    ovf_d   = 1'b1;
                end
            end
            if (brkHit) begin
                halt_d  = 1'b1;
                state_d = FROZEN;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (doWrite && !pop && !full) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !doWrite) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            halt_q  <= halt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Free-running machine-cycle stamp, independent of capture state.
    always_ff @(posedge clk) begin
        if (reset) begin
            stamp_q <= '0;
        end else if (debugIn.machineCycleDone) begin
            stamp_q <= stamp_q + STAMP_W'(1);
        end
    end

    // Trace storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!reset && doWrite) begin
            mem_q[wrPtr_q] <= entry;
        end
    end

    assign haltRequest = halt_q;
    assign frozen      = (state_q == FROZEN);
    assign overflow    = ovf_q;
    assign count       = count_q;
    assign readValid   = (count_q != '0);
    assign readData    = mem_q[rdPtr_q];

endmodule
`default_nettype wire

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Consumes the `debugPkg::debugLines` bundle from the cpu32e2 core.
- On every retired machine cycle, captures a compact trace entry (PC, flags, cause, interrupt enable, cycle stamp) into a circular buffer.
- Provides a PC-match breakpoint that freezes capture and raises a sticky halt request to the debug controller.
- Provides a first-word-fall-through valid/ready read port so the host debug link can drain the trace.

Parameters:
- DEPTH, 16, number of trace entries; power of two, at least 2.
- STAMP_W, 16, width of the machine-cycle stamp counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- debugIn  input  debugPkg::debugLines (1124 bits)  core debug bundle; uses machineCycleDone, nextPCState, flagsState, causeState, interruptEnableState.
- enable  input  1  capture enable.
- stopOnFull  input  1  1 = freeze when full; 0 = overwrite the oldest entry.
- breakEnable  input  1  enables the PC breakpoint.
- breakAddress  input  32  breakpoint PC.
- clearTrace  input  1  single-cycle pulse: empty the buffer, clear overflow and halt, re-arm.
- haltRequest  output  1  sticky; set when the breakpoint hits.
- frozen  output  1  1 while in FROZEN.
- overflow  output  1  sticky; at least one entry was overwritten.
- count  output  $clog2(DEPTH)+1  entries held.
- readValid  output  1  count != 0.
- readReady  input  1  host accepts the head entry.
- readData  output  STAMP_W+42  {stamp, cause[4:0], ie, flags[3:0], pc[31:0]}; head entry, combinational from the read pointer.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = ARMED.
  - Read pointer, write pointer, count, stamp = 0.
  - haltRequest, overflow, frozen, readValid = 0.
  - readData is don't-care while readValid = 0.
  - Storage contents are not reset.
- Stamp counter:
  - Increments by 1 on every cycle with debugIn.machineCycleDone = 1, in any state and regardless of enable.
  - Wraps to 0 from 2^STAMP_W-1.
  - An entry records the pre-increment value.
- States:
  - ARMED: capture allowed.
  - FROZEN: no capture; readout continues.
- Capture condition: state == ARMED && enable && machineCycleDone && !clearTrace. Entry is written at the write pointer.
- Breakpoint:
  - Hits when the capture condition holds, breakEnable = 1, and nextPCState == breakAddress.
  - The matching entry is stored.
  - haltRequest is set on the next edge; state goes to FROZEN.
- Full handling:
  - Full with stopOnFull = 1: a capture that would exceed DEPTH is dropped and state goes to FROZEN. haltRequest is unaffected.
  - Full with stopOnFull = 0 and no pop: the entry overwrites the oldest, both pointers advance, count stays DEPTH, overflow is set.
- Pop: readValid && readReady advances the read pointer and decrements count.
- Push and pop in the same cycle:
  - Both pointers advance; count is unchanged; no overflow, even when full.
  - With stopOnFull = 1 and full, push plus pop is accepted and does not freeze.
- Pointer wrap: both pointers wrap modulo DEPTH.
- clearTrace:
  - Highest priority after reset.
  - Next edge: pointers and count = 0; overflow, haltRequest = 0; state = ARMED.
  - stamp is not cleared.
  - Any capture or pop in the same cycle is ignored.
- frozen = (state == FROZEN). FROZEN exits only via clearTrace or reset.
- Latency:
  - An entry captured at edge N is visible on readData/readValid after edge N.
  - haltRequest rises at the same edge.
- Reset mid-operation discards all entries and stamp; the first capture after reset carries stamp 0.

Test Plan:
- Reset, then 3 machineCycleDone pulses with PC 0x100, 0x104, 0x108 and enable = 1 -> count = 3; reads return PCs in order with stamps 0, 1, 2; readValid drops after the third pop.
- breakEnable = 1, breakAddress = 0x200, PCs 0x1F8, 0x1FC, 0x200, 0x204 -> 3 entries; haltRequest = 1 and frozen = 1 after the 0x200 edge; 0x204 not captured; its stamp still increments to 4.
- DEPTH = 16, stopOnFull = 0, 20 captures with PC = 4*i, no reads -> count = 16, overflow = 1, first read PC = 0x10 (i = 4), last read PC = 0x4C.
- stopOnFull = 1, 17 captures -> count = 16, frozen = 1, haltRequest = 0; clearTrace -> count = 0, frozen = 0; the next capture has stamp 17.
- Full buffer, stopOnFull = 1, capture and readReady in the same cycle -> count stays 16, not frozen, head advances by one, write pointer wraps to the slot just freed.
- clearTrace asserted in the same cycle as a breakpoint-matching capture -> no entry stored, haltRequest = 0, state ARMED.
